serial_add_ctrl: RTL and testbench

//  Bit-serial adder controller. Sequences one shared mux-based full-adder cell over WIDTH

---
 rtl/serial_add_ctrl_pkg.sv | 14 +
 rtl/serial_add_ctrl_if.sv | 26 ++
 rtl/serial_add_ctrl_fa_mux8_cell.sv | 16 +
 rtl/serial_add_ctrl.sv | 112 +++++++++++
 tb/tb_serial_add_ctrl.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM states and
// the full-adder truth tables used as mux tie-offs (bit k = cell input ik).
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [7:0] FA_SUM_TBL = 8'b1001_0110;
  localparam logic [7:0] FA_CRY_TBL = 8'b1110_1000;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Requester-side bundle of the serial adder: start/done handshake, operands
// and the held result.
interface serial_add_ctrl_if #(
  parameter int unsigned WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/serial_add_ctrl_fa_mux8_cell.sv
// One-bit full adder built as two 8:1 muxes selecting from constant tables;
// s_i = {a, b, carry_in}.
module fa_mux8_cell
  import serial_add_pkg::*;
(
  input  logic [2:0] s_i,
  output logic       sum_o,
  output logic       carry_o
);

  always_comb begin
    sum_o   = FA_SUM_TBL[s_i];
    carry_o = FA_CRY_TBL[s_i];
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one shared full-adder cell walks the operands
// LSB first over WIDTH cycles, then publishes {cout,sum} with a done pulse.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  serial_add_ctrl_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             cell_sum;
  logic             cell_carry;

  fa_mux8_cell u_cell (
    .s_i     ({a_sh_q[0], b_sh_q[0], c_q}),
    .sum_o   (cell_sum),
    .carry_o (cell_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    done_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_sh_d   = bus.a;
          b_sh_d   = bus.b;
          c_d      = bus.cin;
          cnt_d    = '0;
          sum_sh_d = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = {cell_sum, sum_sh_q[WIDTH-1:1]};
        c_d      = cell_carry;
        // Counter parks at WIDTH-1 so it never leaves its legal range.
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        sum_d   = sum_sh_q;
        cout_d  = c_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH 8, 2 and 16 against an
// arithmetic/schedule reference model.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst;
  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [2:0]       start_r, cin_r;
  logic [2:0][31:0] a_r, b_r;
  logic [2:0]       busy_w, done_w, cout_w;
  logic [2:0][31:0] sum_w;

  logic [31:0] last_sum  [3];
  logic        last_cout [3];

  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(8))  if8  ();
  serial_add_ctrl_if #(.WIDTH(2))  if2  ();
  serial_add_ctrl_if #(.WIDTH(16)) if16 ();

  serial_add_ctrl #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8));
  serial_add_ctrl #(.WIDTH(2))  u_dut2  (.clk(clk), .rst(rst), .bus(if2));
  serial_add_ctrl #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));

  assign if8.start  = start_r[0];
  assign if8.a      = a_r[0][7:0];
  assign if8.b      = b_r[0][7:0];
  assign if8.cin    = cin_r[0];
  assign if2.start  = start_r[1];
  assign if2.a      = a_r[1][1:0];
  assign if2.b      = b_r[1][1:0];
  assign if2.cin    = cin_r[1];
  assign if16.start = start_r[2];
  assign if16.a     = a_r[2][15:0];
  assign if16.b     = b_r[2][15:0];
  assign if16.cin   = cin_r[2];

  assign busy_w[0] = if8.busy;
  assign done_w[0] = if8.done;
  assign cout_w[0] = if8.cout;
  assign sum_w[0]  = 32'(if8.sum);
  assign busy_w[1] = if2.busy;
  assign done_w[1] = if2.done;
  assign cout_w[1] = if2.cout;
  assign sum_w[1]  = 32'(if2.sum);
  assign busy_w[2] = if16.busy;
  assign done_w[2] = if16.done;
  assign cout_w[2] = if16.cout;
  assign sum_w[2]  = 32'(if16.sum);

  function automatic int wid(input int k);
    case (k)
      0:       return 8;
      1:       return 2;
      default: return 16;
    endcase
  endfunction

  function automatic logic [31:0] mask_of(input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    return m[31:0];
  endfunction

  // Reference: plain integer addition truncated to WIDTH+1 bits.
  function automatic logic [63:0] golden(input int w, input logic [31:0] a,
                                         input logic [31:0] b, input logic c);
    logic [63:0] s;
    s = 64'(a & mask_of(w)) + 64'(b & mask_of(w)) + 64'(c);
    return s & ((64'd1 << (w + 1)) - 64'd1);
  endfunction

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      if (busy_w[k] !== 1'b0) begin
        failures++; $display("FAIL reset_busy w=%0d got=%b exp=0", wid(k), busy_w[k]);
      end
      checks++;
      if (done_w[k] !== 1'b0) begin
        failures++; $display("FAIL reset_done w=%0d got=%b exp=0", wid(k), done_w[k]);
      end
      checks++;
      if (sum_w[k] !== 32'd0) begin
        failures++; $display("FAIL reset_sum w=%0d got=%h exp=0", wid(k), sum_w[k]);
      end
      checks++;
      if (cout_w[k] !== 1'b0) begin
        failures++; $display("FAIL reset_cout w=%0d got=%b exp=0", wid(k), cout_w[k]);
      end
      checks++;
    end
  endtask

  // One operation on instance k; optional one-cycle start poke at cycle poke_j.
  task automatic test_op(input int k, input logic [31:0] a, input logic [31:0] b,
                         input logic c, input logic [31:0] es, input logic ec,
                         input int poke_j, input string name);
    int w, done_at, ndone, nbusy;
    logic [31:0] exp_s;
    logic        exp_c;
    w = wid(k);
    done_at = -1; ndone = 0; nbusy = 0;
    @(negedge clk);
    start_r[k] = 1'b1; a_r[k] = a; b_r[k] = b; cin_r[k] = c;
    for (int j = 0; j <= w + 4; j++) begin
      @(negedge clk);
      if (busy_w[k] === 1'b1) nbusy++;
      if (done_w[k] === 1'b1) begin
        ndone++;
        if (done_at < 0) done_at = j;
      end
      exp_s = (j >= w + 1) ? es : last_sum[k];
      exp_c = (j >= w + 1) ? ec : last_cout[k];
      if (sum_w[k] !== exp_s || cout_w[k] !== exp_c) begin
        failures++;
        $display("FAIL %s_result cyc=%0d got=%b/%h exp=%b/%h", name, j,
                 cout_w[k], sum_w[k], exp_c, exp_s);
      end
      checks++;
      if (j == 0) begin
        start_r[k] = 1'b0;
        a_r[k] = $urandom & mask_of(w);
        b_r[k] = $urandom & mask_of(w);
        cin_r[k] = 1'($urandom);
      end
      if (j == poke_j) begin
        start_r[k] = 1'b1; a_r[k] = 32'd1; b_r[k] = 32'd1;
      end
      if (j == poke_j + 1) start_r[k] = 1'b0;
    end
    if (done_at != w + 1) begin
      failures++; $display("FAIL %s_latency got=%0d exp=%0d", name, done_at, w + 1);
    end
    checks++;
    if (ndone != 1) begin
      failures++; $display("FAIL %s_done_pulses got=%0d exp=1", name, ndone);
    end
    checks++;
    if (nbusy != w + 1) begin
      failures++; $display("FAIL %s_busy_cycles got=%0d exp=%0d", name, nbusy, w + 1);
    end
    checks++;
    last_sum[k]  = es;
    last_cout[k] = ec;
  endtask

  task automatic test_reset_mid_run();
    int w, ndone, nbusy;
    w = wid(0);
    ndone = 0; nbusy = 0;
    @(negedge clk);
    start_r[0] = 1'b1; a_r[0] = 32'hFF; b_r[0] = 32'h01; cin_r[0] = 1'b0;
    @(negedge clk);
    start_r[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    if (busy_w[0] !== 1'b0 || done_w[0] !== 1'b0 || sum_w[0] !== 32'd0 || cout_w[0] !== 1'b0) begin
      failures++;
      $display("FAIL midrun_reset got busy=%b done=%b sum=%h cout=%b exp all 0",
               busy_w[0], done_w[0], sum_w[0], cout_w[0]);
    end
    checks++;
    for (int k = 0; k < 3; k++) begin
      last_sum[k] = 32'd0; last_cout[k] = 1'b0;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < w + 4; j++) begin
      @(negedge clk);
      if (done_w[0] === 1'b1) ndone++;
      if (busy_w[0] === 1'b1) nbusy++;
    end
    if (ndone != 0 || nbusy != 0) begin
      failures++; $display("FAIL midrun_no_done got done=%0d busy=%0d exp=0/0", ndone, nbusy);
    end
    checks++;
  endtask

  // start held high for three operations; model predicts accepts every WIDTH+2 cycles.
  task automatic test_back_to_back(input int k);
    int w, n, next_drive, accepted, ndone, last_acc;
    int acc_q[$];
    logic [63:0] res_q[$];
    logic busy_e, done_e;
    logic [31:0] exp_s;
    logic exp_c;
    logic [63:0] g;
    w = wid(k);
    n = 0; next_drive = 0; accepted = 0; ndone = 0; last_acc = 0;
    repeat (2) @(negedge clk);
    while (n < 200) begin
      @(negedge clk);
      busy_e = 1'b0; done_e = 1'b0;
      exp_s = last_sum[k]; exp_c = last_cout[k];
      for (int i = 0; i < acc_q.size(); i++) begin
        if (acc_q[i] <= n && n <= acc_q[i] + w) busy_e = 1'b1;
        if (n == acc_q[i] + w + 1) done_e = 1'b1;
        if (n >= acc_q[i] + w + 1) begin
          exp_s = res_q[i][31:0] & mask_of(w);
          exp_c = res_q[i][w];
        end
      end
      if (done_w[k] === 1'b1) ndone++;
      if (busy_w[k] !== busy_e || done_w[k] !== done_e) begin
        failures++;
        $display("FAIL b2b_w%0d_handshake n=%0d got busy=%b done=%b exp busy=%b done=%b",
                 w, n, busy_w[k], done_w[k], busy_e, done_e);
      end
      checks++;
      if (sum_w[k] !== exp_s || cout_w[k] !== exp_c) begin
        failures++;
        $display("FAIL b2b_w%0d_result n=%0d got=%b/%h exp=%b/%h",
                 w, n, cout_w[k], sum_w[k], exp_c, exp_s);
      end
      checks++;
      if (accepted == 3 && n >= last_acc + w + 3) break;
      if (accepted < 3) begin
        start_r[k] = 1'b1;
        a_r[k] = $urandom & mask_of(w);
        b_r[k] = $urandom & mask_of(w);
        cin_r[k] = 1'($urandom);
        if (n == next_drive) begin
          g = golden(w, a_r[k], b_r[k], cin_r[k]);
          acc_q.push_back(n + 1);
          res_q.push_back(g);
          last_acc = n + 1;
          accepted++;
          next_drive = n + w + 2;
        end
      end else begin
        start_r[k] = 1'b0;
      end
      n++;
    end
    start_r[k] = 1'b0;
    if (ndone != 3) begin
      failures++; $display("FAIL b2b_w%0d_done_count got=%0d exp=3", w, ndone);
    end
    checks++;
    last_sum[k]  = exp_s;
    last_cout[k] = exp_c;
  endtask

  initial begin
    rst = 1'b1;
    start_r = '0; cin_r = '0; a_r = '0; b_r = '0;
    for (int k = 0; k < 3; k++) begin
      last_sum[k] = 32'd0; last_cout[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_op(0, 32'h35, 32'h4A, 1'b0, 32'h7F, 1'b0, -1, "basic");
    test_op(0, 32'hFF, 32'h00, 1'b1, 32'h00, 1'b1, -1, "ripple");
    test_op(0, 32'hFF, 32'hFF, 1'b1, 32'hFF, 1'b1, -1, "max");
    test_op(0, 32'h5A, 32'h3C, 1'b1, 32'h97, 1'b0, 3, "start_ignored");
    test_reset_mid_run();
    test_back_to_back(0);
    test_back_to_back(1);
    test_back_to_back(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
